dmem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM pipe stage: turns the EX/MEM register's load/store request into a single-outstanding req/ack bus transaction and drives `memReady` to the pipeline stall control, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while `memReady` is low. It also performs byte-lane alignment for stores, extraction and sign-extension for loads, and misalignment detection. It is the responder end of the `memReady` stall handshake.

---
 rtl/dmem_access_ctrl_pkg.sv | 17 +
 rtl/dmem_access_ctrl_load_store_align.sv | 56 +++++
 rtl/dmem_access_ctrl.sv | 112 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: funct3 size codes
// and the access FSM states.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dmem_access_ctrl_load_store_align.sv
// Byte-lane logic for the MEM stage: store enables/replication and misalignment
// from the live request, load extraction/extension from the captured access.
module load_store_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  req_lo,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  ld_lo,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    be         = 4'b0000;
    wdata      = req_wdata;
    misaligned = 1'b0;
    case (req_funct3)
      F3_LB, F3_LBU: begin
        be    = 4'b0001 << req_lo;
        wdata = {4{req_wdata[7:0]}};
      end
      F3_LH, F3_LHU: begin
        be         = req_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{req_wdata[15:0]}};
        misaligned = req_lo[0];
      end
      F3_LW: begin
        be         = 4'b1111;
        misaligned = |req_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata[{ld_lo, 3'b000} +: 8];
    half_sel = ld_lo[1] ? rdata[31:16] : rdata[15:0];
    ldata    = rdata;
    case (ld_funct3)
      F3_LB:   ldata = 32'(byte_sel);
      F3_LBU:  ldata = {24'd0, byte_sel};
      F3_LH:   ldata = 32'(half_sel);
      F3_LHU:  ldata = {16'd0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: one outstanding req/ack bus transaction per
// load/store, with memReady driving the pipeline stall.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          exmem_memRead,
  input  logic          exmem_memWrite,
  input  logic [AW-1:0] exmem_addr,
  input  logic [DW-1:0] exmem_wdata,
  input  logic [2:0]    exmem_funct3,
  output logic          memReady,
  output logic [DW-1:0] load_data,
  output logic          mem_misaligned,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  dm_state_e   state, state_nxt;
  logic [1:0]  ld_lo;
  logic [2:0]  ld_funct3;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ldata_c;
  logic        misal_c, req_any, access;

  assign req_any        = exmem_memRead | exmem_memWrite;
  assign mem_misaligned = req_any & misal_c;
  assign access         = req_any & ~misal_c;

  // Load extraction uses the captured offset/size since EX/MEM may change while BUSY.
  load_store_align u_align (
    .req_lo     (exmem_addr[1:0]),
    .req_funct3 (exmem_funct3),
    .req_wdata  (exmem_wdata),
    .ld_lo      (ld_lo),
    .ld_funct3  (ld_funct3),
    .rdata      (bus_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .ldata      (ldata_c),
    .misaligned (misal_c)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= DM_IDLE;
    else       state <= state_nxt;
  end

  // DONE releases the pipeline for one cycle without re-issuing the same instruction.
  always_comb begin
    state_nxt = state;
    memReady  = 1'b1;
    case (state)
      DM_IDLE: begin
        if (access) begin
          state_nxt = DM_BUSY;
          memReady  = 1'b0;
        end
      end
      DM_BUSY: begin
        memReady = 1'b0;
        if (bus_ack) state_nxt = DM_DONE;
      end
      DM_DONE: state_nxt = DM_IDLE;
      default: state_nxt = DM_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= 4'b0000;
      load_data <= '0;
      ld_lo     <= 2'b00;
      ld_funct3 <= 3'b000;
    end else begin
      case (state)
        DM_IDLE: begin
          if (access) begin
            bus_req   <= 1'b1;
            bus_we    <= exmem_memWrite;
            bus_addr  <= {exmem_addr[AW-1:2], 2'b00};
            bus_wdata <= wdata_c;
            bus_be    <= be_c;
            ld_lo     <= exmem_addr[1:0];
            ld_funct3 <= exmem_funct3;
          end
        end
        DM_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) load_data <= ldata_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a configurable-wait bus responder.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exmem_memRead = 1'b0, exmem_memWrite = 1'b0;
  logic [31:0] exmem_addr = '0, exmem_wdata = '0;
  logic [2:0]  exmem_funct3 = 3'b000;
  logic        memReady, mem_misaligned, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  dmem_access_ctrl #(.AW(32), .DW(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .exmem_memRead  (exmem_memRead),
    .exmem_memWrite (exmem_memWrite),
    .exmem_addr     (exmem_addr),
    .exmem_wdata    (exmem_wdata),
    .exmem_funct3   (exmem_funct3),
    .memReady       (memReady),
    .load_data      (load_data),
    .mem_misaligned (mem_misaligned),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          stall;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_load = '0;

  int   req_rises = 0, low_run = 0, last_gap = 0;
  logic prev_req = 1'b0;

  always @(negedge clock) begin
    if (bus_req && !prev_req) begin
      req_rises = req_rises + 1;
      last_gap  = low_run;
    end
    low_run  = bus_req ? 0 : low_run + 1;
    prev_req = bus_req;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drop_inputs();
    exmem_memRead  = 1'b0;
    exmem_memWrite = 1'b0;
    exmem_addr     = '0;
    exmem_wdata    = '0;
    exmem_funct3   = 3'b000;
  endtask

  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int waits, input logic [31:0] e_addr,
                            input logic [3:0] e_be, input logic [31:0] e_wdata,
                            input logic [31:0] e_ld);
    exp_t e, got;
    int   stall = 0, busy = 0;
    bit   seen = 1'b0, done = 1'b0;
    e.we    = wr;
    e.addr  = e_addr;
    e.be    = e_be;
    e.wdata = e_wdata;
    e.ld    = wr ? last_load : e_ld;
    e.stall = 2 + waits;
    last_load = e.ld;
    sb_q.push_back(e);

    @(posedge clock); #1;
    exmem_memRead  = rd;
    exmem_memWrite = wr;
    exmem_funct3   = f3;
    exmem_addr     = addr;
    exmem_wdata    = wdata;

    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clock);
      if (!memReady) stall++;
      if (bus_req) begin
        if (!seen) begin
          seen = 1'b1;
          got  = sb_q.pop_front();
          check({tag, "_we"},    32'(bus_we), 32'(got.we));
          check({tag, "_addr"},  bus_addr,    got.addr);
          check({tag, "_be"},    32'(bus_be), 32'(got.be));
          check({tag, "_wdata"}, bus_wdata,   got.wdata);
        end
        if (busy == waits) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = 32'h5A5A5A5A;
        end
        busy++;
      end else if (seen) begin
        check({tag, "_ready_done"}, 32'(memReady), 32'd1);
        check({tag, "_load"},       load_data,     got.ld);
        check({tag, "_stall"},      32'(stall),    32'(got.stall));
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        drop_inputs();
        done = 1'b1;
      end
    end
    if (!done) begin
      check({tag, "_completed"}, 32'(done), 32'd1);
      if (!seen && sb_q.size() > 0) void'(sb_q.pop_front());
      bus_ack = 1'b0;
      drop_inputs();
    end
  endtask

  initial begin
    int r0;
    bit found;

    repeat (2) @(negedge clock);
    check("rst_req",   32'(bus_req),        32'd0);
    check("rst_we",    32'(bus_we),         32'd0);
    check("rst_addr",  bus_addr,            32'd0);
    check("rst_wdata", bus_wdata,           32'd0);
    check("rst_be",    32'(bus_be),         32'd0);
    check("rst_load",  load_data,           32'd0);
    check("rst_ready", 32'(memReady),       32'd1);
    check("rst_misal", 32'(mem_misaligned), 32'd0);
    reset = 1'b0;

    run_access("lw",    1, 0, 3'b010, 32'h1004, 32'h0,        32'hDEADBEEF, 1, 32'h1004, 4'b1111, 32'h0,        32'hDEADBEEF);
    run_access("lb",    1, 0, 3'b000, 32'h2003, 32'h0,        32'h80FFFFFF, 0, 32'h2000, 4'b1000, 32'h0,        32'hFFFFFF80);
    run_access("lbu",   1, 0, 3'b100, 32'h2003, 32'h0,        32'h80FFFFFF, 0, 32'h2000, 4'b1000, 32'h0,        32'h00000080);
    run_access("sh",    0, 1, 3'b001, 32'h3002, 32'h0000ABCD, 32'hFFFFFFFF, 0, 32'h3000, 4'b1100, 32'hABCDABCD, 32'h0);
    run_access("sb",    0, 1, 3'b000, 32'h5001, 32'h123456A7, 32'hFFFFFFFF, 2, 32'h5000, 4'b0010, 32'hA7A7A7A7, 32'h0);
    run_access("lh_hi", 1, 0, 3'b001, 32'h6002, 32'h0,        32'h80011234, 0, 32'h6000, 4'b1100, 32'h0,        32'hFFFF8001);
    run_access("lhu",   1, 0, 3'b101, 32'h6000, 32'h0,        32'h80011234, 0, 32'h6000, 4'b0011, 32'h0,        32'h00001234);
    run_access("lh_lo", 1, 0, 3'b001, 32'h6000, 32'h0,        32'h7FFF8000, 0, 32'h6000, 4'b0011, 32'h0,        32'hFFFF8000);
    run_access("sw",    0, 1, 3'b010, 32'h7000, 32'hCAFEF00D, 32'hFFFFFFFF, 3, 32'h7000, 4'b1111, 32'hCAFEF00D, 32'h0);
    run_access("rdwr",  1, 1, 3'b010, 32'h7008, 32'h11223344, 32'hFFFFFFFF, 0, 32'h7008, 4'b1111, 32'h11223344, 32'h0);
    run_access("lb_pos",1, 0, 3'b000, 32'h7001, 32'h0,        32'h00007F00, 0, 32'h7000, 4'b0010, 32'h0,        32'h0000007F);

    // Misaligned requests never reach the bus and never stall.
    r0 = req_rises;
    @(posedge clock); #1;
    exmem_memRead = 1'b1; exmem_funct3 = 3'b010; exmem_addr = 32'h4001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("lw_mis_flag",  32'(mem_misaligned), 32'd1);
      check("lw_mis_ready", 32'(memReady),       32'd1);
      check("lw_mis_req",   32'(bus_req),        32'd0);
    end
    exmem_memRead = 1'b0; exmem_memWrite = 1'b1; exmem_funct3 = 3'b001; exmem_addr = 32'h3001;
    @(negedge clock);
    check("sh_mis_flag",  32'(mem_misaligned), 32'd1);
    check("sh_mis_ready", 32'(memReady),       32'd1);
    drop_inputs();
    @(negedge clock);
    check("mis_no_req", 32'(req_rises - r0), 32'd0);

    // Back-to-back: low during DONE and the following IDLE-stall cycle.
    r0 = req_rises;
    run_access("b2b_1", 1, 0, 3'b010, 32'h8000, 32'h0, 32'h01020304, 0, 32'h8000, 4'b1111, 32'h0, 32'h01020304);
    run_access("b2b_2", 1, 0, 3'b010, 32'h8004, 32'h0, 32'h05060708, 0, 32'h8004, 4'b1111, 32'h0, 32'h05060708);
    repeat (3) @(negedge clock);
    check("b2b_rises", 32'(req_rises - r0), 32'd2);
    check("b2b_gap",   32'(last_gap),       32'd2);

    // Reset in BUSY discards the transaction; a later stray ack is ignored.
    @(posedge clock); #1;
    exmem_memRead = 1'b1; exmem_funct3 = 3'b010; exmem_addr = 32'h9000;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (bus_req) found = 1'b1;
    end
    check("rstbusy_reached", 32'(found), 32'd1);
    reset = 1'b1;
    drop_inputs();
    @(negedge clock);
    reset = 1'b0;
    last_load = '0;
    check("rstbusy_req",   32'(bus_req),  32'd0);
    check("rstbusy_ready", 32'(memReady), 32'd1);
    check("rstbusy_load",  load_data,     last_load);
    r0 = req_rises;
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    bus_ack = 1'b0;
    repeat (2) @(negedge clock);
    check("stray_req",   32'(bus_req),          32'd0);
    check("stray_ready", 32'(memReady),         32'd1);
    check("stray_load",  load_data,             last_load);
    check("stray_rises", 32'(req_rises - r0),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
